// File: rtl/mc_controller.sv
// Multicycle MIPS-style control FSM.
// Moore-decoded datapath strobes plus PC enable.
module mc_controller #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t cur, nxt;
  logic   pcwrite, branch;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt      = FETCH;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    alu_ctrl = ALU_ADD;
    case (cur)
      FETCH: begin
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYP:      nxt = EXECUTE;
          OP_BEQ:       nxt = BRANCH;
          OP_ADDI:      nxt = ADDIEXEC;
          OP_J:         nxt = JUMP;
          default:      nxt = ILLEGAL_HALT ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        nxt  = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        nxt     = ALUWB;
        case (funct)
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b101010: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        alu_ctrl = ALU_SUB;
        pcsrc    = 2'b01;
        branch   = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB:  regwrite = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      HALT:    nxt = HALT;
      // Unused codes 12-14 fall back to FETCH with everything low.
      default: nxt = FETCH;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller.
// Two instances cover both ILLEGAL_HALT settings.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;

  logic       pcen, irwrite, memwrite, regwrite;
  logic       iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  logic       h_pcen, h_irwrite, h_memwrite, h_regwrite;
  logic       h_iord, h_memtoreg, h_regdst, h_alusrca;
  logic [1:0] h_alusrcb, h_pcsrc;
  logic [2:0] h_alu_ctrl;
  logic [3:0] h_state;

  logic [14:0] outs, h_outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_controller #(.ILLEGAL_HALT(1'b0)) u_dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alu_ctrl(alu_ctrl), .state(state)
  );

  mc_controller #(.ILLEGAL_HALT(1'b1)) u_halt (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(h_pcen), .irwrite(h_irwrite), .memwrite(h_memwrite),
    .regwrite(h_regwrite), .iord(h_iord), .memtoreg(h_memtoreg),
    .regdst(h_regdst), .alusrca(h_alusrca), .alusrcb(h_alusrcb),
    .pcsrc(h_pcsrc), .alu_ctrl(h_alu_ctrl), .state(h_state)
  );

  assign outs = {pcen, irwrite, memwrite, regwrite, iord,
                 memtoreg, regdst, alusrca, alusrcb, pcsrc, alu_ctrl};
  assign h_outs = {h_pcen, h_irwrite, h_memwrite, h_regwrite, h_iord,
                   h_memtoreg, h_regdst, h_alusrca, h_alusrcb,
                   h_pcsrc, h_alu_ctrl};

  // {pcen,irw,memw,regw,iord,mtr,rdst,asa}_alusrcb_pcsrc_aluctrl
  localparam logic [14:0] O_FETCH = 15'b11000000_01_00_000;
  localparam logic [14:0] O_DEC   = 15'b00000000_11_00_000;
  localparam logic [14:0] O_MADR  = 15'b00000001_10_00_000;
  localparam logic [14:0] O_MRD   = 15'b00001000_00_00_000;
  localparam logic [14:0] O_MWB   = 15'b00010100_00_00_000;
  localparam logic [14:0] O_MWR   = 15'b00101000_00_00_000;
  localparam logic [14:0] O_AWB   = 15'b00010010_00_00_000;
  localparam logic [14:0] O_BR_Z  = 15'b10000001_00_01_001;
  localparam logic [14:0] O_BR_NZ = 15'b00000001_00_01_001;
  localparam logic [14:0] O_AIWB  = 15'b00010000_00_00_000;
  localparam logic [14:0] O_JMP   = 15'b10000000_00_10_000;
  localparam logic [14:0] O_NONE  = 15'b00000000_00_00_000;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100,
                             6'b100101, 6'b101010, 6'b111111};
  logic [2:0] al_tab [6] = '{3'b000, 3'b001, 3'b010,
                             3'b011, 3'b101, 3'b000};

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check current state and outputs, then advance one cycle.
  task automatic cyc(input string tag, input logic [3:0] st,
                     input logic [14:0] o);
    chk({tag, ".st"}, {12'd0, state}, {12'd0, st});
    chk({tag, ".o"}, {1'b0, outs}, {1'b0, o});
    tick();
  endtask

  initial begin
    reset = 1'b1;
    op    = OP_LW;
    funct = 6'd0;
    zero  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    cyc("lw0", 4'd0, O_FETCH);
    cyc("lw1", 4'd1, O_DEC);
    cyc("lw2", 4'd2, O_MADR);
    cyc("lw3", 4'd3, O_MRD);
    cyc("lw4", 4'd4, O_MWB);

    op = OP_SW;
    cyc("sw0", 4'd0, O_FETCH);
    cyc("sw1", 4'd1, O_DEC);
    cyc("sw2", 4'd2, O_MADR);
    cyc("sw3", 4'd5, O_MWR);

    for (int i = 0; i < 6; i++) begin
      op    = 6'b000000;
      funct = fn_tab[i];
      cyc($sformatf("r%0d.0", i), 4'd0, O_FETCH);
      cyc($sformatf("r%0d.1", i), 4'd1, O_DEC);
      cyc($sformatf("r%0d.2", i), 4'd6,
          {8'b00000001, 2'b00, 2'b00, al_tab[i]});
      cyc($sformatf("r%0d.3", i), 4'd7, O_AWB);
    end

    op   = OP_BEQ;
    zero = 1'b1;
    cyc("beqz0", 4'd0, O_FETCH);
    cyc("beqz1", 4'd1, O_DEC);
    cyc("beqz2", 4'd8, O_BR_Z);
    zero = 1'b0;
    cyc("beqn0", 4'd0, O_FETCH);
    cyc("beqn1", 4'd1, O_DEC);
    cyc("beqn2", 4'd8, O_BR_NZ);

    op = OP_ADDI;
    cyc("addi0", 4'd0, O_FETCH);
    cyc("addi1", 4'd1, O_DEC);
    cyc("addi2", 4'd9, O_MADR);
    cyc("addi3", 4'd10, O_AIWB);

    op = OP_J;
    cyc("j0", 4'd0, O_FETCH);
    cyc("j1", 4'd1, O_DEC);
    cyc("j2", 4'd11, O_JMP);

    // op changes outside sampling states must not matter
    op = OP_LW;
    cyc("lwx0", 4'd0, O_FETCH);
    cyc("lwx1", 4'd1, O_DEC);
    cyc("lwx2", 4'd2, O_MADR);
    op = OP_SW;
    cyc("lwx3", 4'd3, O_MRD);
    cyc("lwx4", 4'd4, O_MWB);

    op = OP_LW;
    cyc("rst0", 4'd0, O_FETCH);
    cyc("rst1", 4'd1, O_DEC);
    cyc("rst2", 4'd2, O_MADR);
    chk("rst3.st", {12'd0, state}, 16'd3);
    chk("rst3.wr", {14'd0, memwrite, regwrite}, 16'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst4.st", {12'd0, state}, 16'd0);
    chk("rst4.o", {1'b0, outs}, {1'b0, O_FETCH});
    chk("rst4.h", {12'd0, h_state}, 16'd0);

    op = OP_BAD;
    tick();
    chk("ill1.st", {12'd0, state}, 16'd1);
    chk("ill1.hst", {12'd0, h_state}, 16'd1);
    tick();
    chk("ill2.st", {12'd0, state}, 16'd0);
    chk("ill2.hst", {12'd0, h_state}, 16'd15);
    chk("ill2.ho", {1'b0, h_outs}, {1'b0, O_NONE});
    op   = OP_LW;
    zero = 1'b1;
    tick();
    chk("ill3.st", {12'd0, state}, 16'd1);
    chk("ill3.hst", {12'd0, h_state}, 16'd15);
    chk("ill3.ho", {1'b0, h_outs}, {1'b0, O_NONE});
    tick();
    chk("ill4.hst", {12'd0, h_state}, 16'd15);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    zero  = 1'b0;
    chk("ill5.hst", {12'd0, h_state}, 16'd0);
    chk("ill5.ho", {1'b0, h_outs}, {1'b0, O_FETCH});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter ILLEGAL_HALT, default 0: 0 = unknown opcode returns to FETCH; 1 = unknown opcode enters HALT.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode from instruction register.
REQ-005 funct  in  6  R-type function field.
REQ-006 zero  in  1  ALU zero flag (1 when ALU result == 0).
REQ-007 pcen  out  1  PC register write enable.
REQ-008 irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca  out  1 each  datapath strobes/selects.
REQ-009 alusrcb  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-010 pcsrc  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 alu_ctrl  out  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, SLT 101.
REQ-012 state  out  4  current state encoding, debug.

Function
REQ-013 Moore FSM; all outputs except pcen are decoded from state only; any output not listed for a state is 0 (alu_ctrl = ADD).
REQ-014 Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, HALT 15; codes 12-14 go to FETCH next cycle with all outputs 0.
REQ-015 FETCH: irwrite=1, alusrcb=01, ADD, pcsrc=00, pcwrite=1; -> DECODE.
REQ-016 DECODE: alusrcb=11, ADD; op 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP, other -> FETCH (or HALT if ILLEGAL_HALT=1).
REQ-017 MEMADR: alusrca=1, alusrcb=10, ADD; op 100011 -> MEMRD, else -> MEMWR.
REQ-018 MEMRD: iord=1 -> MEMWB; MEMWB: memtoreg=1, regwrite=1 -> FETCH.
REQ-019 MEMWR: iord=1, memwrite=1 -> FETCH.
REQ-020 EXECUTE: alusrca=1, alusrcb=00, alu_ctrl from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, other ADD; -> ALUWB.
REQ-021 ALUWB: regdst=1, regwrite=1 -> FETCH.
REQ-022 BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=01, branch=1 (internal) -> FETCH.
REQ-023 ADDIEXEC: alusrca=1, alusrcb=10, ADD -> ADDIWB; ADDIWB: regwrite=1 -> FETCH.
REQ-024 JUMP: pcsrc=10, pcwrite=1 -> FETCH.
REQ-025 HALT: all outputs 0; remains in HALT until reset.
REQ-026 pcen = pcwrite | (branch & zero), combinational; zero is ignored in all states except BRANCH.
REQ-027 Cycles per instruction incl. FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; illegal 2.
REQ-028 op/funct are sampled only in DECODE, MEMADR, EXECUTE; changes elsewhere have no effect.

Reset
REQ-029 reset high at a rising edge forces state=FETCH next cycle, overriding any transition, from any state including HALT and mid-instruction.
REQ-030 While state=FETCH after reset, outputs are the FETCH values (irwrite=1, pcen=1, alusrcb=01); no other output reset value exists since outputs are state-decoded.

Verification
REQ-031 Reset, op=100011: state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-032 op=000000, funct=101010: states 0,1,6,7,0; alu_ctrl=101 in EXECUTE; regdst=1, regwrite=1 in ALUWB.
REQ-033 op=000100 with zero=1 in BRANCH -> pcen=1, pcsrc=01, alu_ctrl=001; repeat with zero=0 -> pcen=0; zero=1 during DECODE -> pcen=0.
REQ-034 op=111111, ILLEGAL_HALT=0 -> states 0,1,0; ILLEGAL_HALT=1 -> 0,1,15,15,... all outputs 0; reset -> 0.
REQ-035 reset asserted while in MEMRD -> next state 0, memwrite and regwrite never 1 during that instruction.
REQ-036 op=101011: states 0,1,2,5,0, memwrite=1 only in MEMWR, regwrite=0 throughout.
